tt_um_mariya_divider: RTL and testbench
=======================================

TT_UM_MARIYA_DIVIDER -- requirements
Module: tt_um_mariya_divider

Interface
REQ-001 Parameters SHALL be none; all widths are fixed.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 ena  input  1  enable; when low, all state SHALL hold.
REQ-005 ui_in  input  8  dividend N, unsigned.
REQ-006 uio_in  input  8  [3:0] divisor D, unsigned; [4] start; [5] result select; [7:6] unused.
REQ-007 uo_out  output  8  result view; sel=0 gives quotient Q[7:0], sel=1 gives {4'b0, remainder R[3:0]}.
REQ-008 uio_out  output  8  [7] busy, [6] done, [5] div_by_zero, [4:0] constant 0.
REQ-009 uio_oe  output  8  constant 8'b1110_0000.

Function
REQ-010 FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-011 IDLE: on an edge with ena=1 and start=1, capture N and D. If D!=0, clear the 3-bit iteration counter and go to RUN. If D==0, go to DONE.
REQ-012 RUN: restoring division, one quotient bit per edge, MSB first.
REQ-013 Each RUN step: partial remainder P (5 bits) = {P[3:0], next N bit}; if P>=D, then P=P-D and the quotient bit is 1, else the quotient bit is 0.
REQ-014 RUN SHALL last exactly 8 edges with ena=1; the 8th edge loads the Q/R result registers and enters DONE.
REQ-015 Latency: with ena held high, done SHALL be visible after the 9th rising edge counted from the capture edge inclusive.
REQ-016 Divide by zero: the capture edge enters DONE directly, sets div_by_zero=1, Q=8'hFF, R=4'hF; done is visible after 1 edge.
REQ-017 On every normal completion, div_by_zero SHALL be 0.
REQ-018 busy=1 exactly in RUN; done=1 exactly in DONE.
REQ-019 start SHALL be ignored while in RUN; captured N and D SHALL NOT change during RUN.
REQ-020 DONE: stay while start=1; go to IDLE on the first ena=1 edge with start=0. This is a level handshake, so a held start SHALL NOT retrigger.
REQ-021 Q, R and div_by_zero result registers SHALL change only on entry to DONE; they are held through IDLE and the next RUN.
REQ-022 uo_out select (uio_in[5]) SHALL be combinational onto the registered results; results SHALL always satisfy N = Q*D + R with R < D when D!=0.
REQ-023 With ena=0, the FSM, counter, datapath and results SHALL freeze; outputs hold their values.

Reset
REQ-024 On an edge with rst_n=0, regardless of ena or state: state=IDLE, counter=0, P=0, Q=0, R=0, busy=0, done=0, div_by_zero=0.
REQ-025 Reset during RUN SHALL abort the division; no partial result appears on outputs.
REQ-026 After reset release, uo_out SHALL be 8'h00 for both sel values until the first completion.

Verification
REQ-027 N=200, D=7, start pulse -> busy for 8 cycles, then done=1; sel=0 gives 8'd28, sel=1 gives 8'd4, div_by_zero=0.
REQ-028 N=255, D=1 -> Q=255, R=0. N=5, D=9 -> Q=0, R=5. N=0, D=15 -> Q=0, R=0.
REQ-029 N=77, D=0 -> done after 1 edge, busy never 1, div_by_zero=1, Q=8'hFF, R=4'hF. Then N=77, D=3 -> Q=25, R=2, div_by_zero=0.
REQ-030 Hold start=1 for 20 cycles with N=100, D=10 -> exactly one division, Q=10, R=0; stays DONE until start=0, then IDLE next edge.
REQ-031 Assert rst_n=0 at the 4th RUN cycle of N=200, D=7 -> next cycle IDLE, busy=0, done=0, outputs 0. A restarted division yields Q=28, R=4.
REQ-032 Drop ena for 5 cycles mid-RUN -> completion delayed by exactly 5 cycles with a correct result. Then run an exhaustive sweep of all 256x16 N/D pairs against the expected Q and R.

Source files
------------

// File: rtl/tt_um_mariya_divider.sv
// rtl/tt_um_mariya_divider.sv - 8-bit by 4-bit restoring divider, one quotient bit per clock

module tt_um_mariya_divider (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        start;
    logic        sel;
    logic [3:0]  d_in;
    logic        unused_bits;

    logic [7:0]  n_reg;
    logic [3:0]  d_reg;
    logic [2:0]  cnt;
    logic [4:0]  p;
    logic [7:0]  q_work;
    logic [7:0]  q_res;
    logic [3:0]  r_res;
    logic        dbz;

    logic [4:0]  p_shift;
    logic [4:0]  p_step;
    logic        q_bit;

    assign d_in        = uio_in[3:0];
    assign start       = uio_in[4];
    assign sel         = uio_in[5];
    assign unused_bits = &{1'b0, uio_in[7:6]};

    // One restoring step: bring down the next dividend bit (MSB first) and trial-subtract.
    always_comb begin
        p_shift = {p[3:0], n_reg[3'd7 - cnt]};
        q_bit   = (p_shift >= {1'b0, d_reg});
        p_step  = q_bit ? (p_shift - {1'b0, d_reg}) : p_shift;
    end

    // State register; ena low freezes the controller, reset wins regardless of ena.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_nx;
        end
    end

    // Next state: divide-by-zero skips RUN; DONE waits for start to drop so a held start cannot retrigger.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = (d_in == 4'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == 3'd7) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: capture operands in IDLE, iterate in RUN, publish results only on entry to DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_reg  <= 8'd0;
            d_reg  <= 4'd0;
            cnt    <= 3'd0;
            p      <= 5'd0;
            q_work <= 8'd0;
            q_res  <= 8'd0;
            r_res  <= 4'd0;
            dbz    <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg  <= ui_in;
                        d_reg  <= d_in;
                        cnt    <= 3'd0;
                        p      <= 5'd0;
                        q_work <= 8'd0;
                        if (d_in == 4'd0) begin
                            q_res <= 8'hFF;
                            r_res <= 4'hF;
                            dbz   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    cnt    <= cnt + 3'd1;
                    p      <= p_step;
                    q_work <= {q_work[6:0], q_bit};
                    if (cnt == 3'd7) begin
                        q_res <= {q_work[6:0], q_bit};
                        r_res <= p_step[3:0];
                        dbz   <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign uo_out  = sel ? {4'b0000, r_res} : q_res;
    assign uio_out = {(state == RUN), (state == DONE), dbz, 5'b00000};
    assign uio_oe  = 8'b1110_0000;

endmodule

// File: tb/tb_tt_um_mariya_divider.sv
// tb/tb_tt_um_mariya_divider.sv - self-checking bench for tt_um_mariya_divider

module tb_tt_um_mariya_divider;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    wire  [7:0] uo_out;
    wire  [7:0] uio_out;
    wire  [7:0] uio_oe;

    int checks = 0;
    int errors = 0;
    int last_q = 0;

    tt_um_mariya_divider dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input int d, input bit start, input bit sel);
        ui_in  = n[7:0];
        uio_in = {2'b00, sel, start, d[3:0]};
        #1;
    endtask

    function automatic int ref_q(input int n, input int d);
        return (d == 0) ? 255 : n / d;
    endfunction

    function automatic int ref_r(input int n, input int d);
        return (d == 0) ? 15 : n % d;
    endfunction

    task automatic check_result(input string tag, input int n, input int d);
        drive(n, d, 0, 0);
        check({tag, "_q"}, uo_out, ref_q(n, d));
        drive(n, d, 0, 1);
        check({tag, "_r"}, uo_out, ref_r(n, d));
        check({tag, "_dbz"}, uio_out[5], (d == 0) ? 1 : 0);
        drive(n, d, 0, 0);
    endtask

    task automatic run_div(input int n, input int d);
        int cyc;
        int busy_cyc;
        drive(n, d, 1, 0);
        tick();
        cyc = 1;
        busy_cyc = uio_out[7] ? 1 : 0;
        drive(n, d, 0, 0);
        if (d != 0) check("held_q", uo_out, last_q);
        while (!uio_out[6] && cyc < 40) begin
            tick();
            cyc++;
            if (uio_out[7]) busy_cyc++;
        end
        check("latency", cyc, (d == 0) ? 1 : 9);
        check("busy_cycles", busy_cyc, (d == 0) ? 0 : 8);
        check("done", uio_out[6], 1);
        check_result("res", n, d);
        last_q = ref_q(n, d);
        tick();
        check("idle_done", uio_out[6], 0);
        check("idle_busy", uio_out[7], 0);
    endtask

    initial begin
        int cyc;
        int busy_cyc;
        rst_n = 1'b0;
        ena   = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        tick();
        check("rst_uo_q", uo_out, 0);
        drive(0, 0, 0, 1);
        check("rst_uo_r", uo_out, 0);
        check("rst_uio_out", uio_out, 0);
        check("uio_oe", uio_oe, 8'hE0);
        rst_n = 1'b1;
        tick();
        check("post_rst_r", uo_out, 0);
        drive(0, 0, 0, 0);
        check("post_rst_q", uo_out, 0);

        run_div(200, 7);
        run_div(255, 1);
        run_div(5, 9);
        run_div(0, 15);
        run_div(77, 0);
        run_div(77, 3);

        // Held start: exactly one division, remains DONE until start drops.
        busy_cyc = 0;
        drive(100, 10, 1, 0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (uio_out[7]) busy_cyc++;
        end
        check("hold_busy_cycles", busy_cyc, 8);
        check("hold_done", uio_out[6], 1);
        check_result("hold", 100, 10);
        drive(100, 10, 0, 0);
        tick();
        check("hold_idle_done", uio_out[6], 0);
        check("hold_idle_busy", uio_out[7], 0);
        last_q = 10;

        // Reset in the 4th RUN cycle aborts the division.
        drive(200, 7, 1, 0);
        tick();
        drive(200, 7, 0, 0);
        tick();
        tick();
        tick();
        check("pre_abort_busy", uio_out[7], 1);
        rst_n = 1'b0;
        tick();
        check("abort_uio_out", uio_out, 0);
        check("abort_q", uo_out, 0);
        drive(200, 7, 0, 1);
        check("abort_r", uo_out, 0);
        rst_n = 1'b1;
        last_q = 0;
        run_div(200, 7);

        // ena low for 5 cycles mid-RUN delays completion by exactly 5 cycles.
        drive(123, 5, 1, 0);
        tick();
        drive(123, 5, 0, 0);
        cyc = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            cyc++;
        end
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            cyc++;
            check("ena_hold_busy", uio_out[7], 1);
        end
        ena = 1'b1;
        while (!uio_out[6] && cyc < 40) begin
            tick();
            cyc++;
        end
        check("ena_latency", cyc, 14);
        check_result("ena", 123, 5);
        tick();
        check("ena_idle", uio_out[6], 0);
        last_q = ref_q(123, 5);

        for (int i = 0; i < 20; i++) begin
            run_div(int'($urandom_range(255, 0)), int'($urandom_range(15, 0)));
        end

        for (int n = 0; n < 256; n++) begin
            for (int d = 0; d < 16; d++) begin
                run_div(n, d);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
